// File: rtl/rv_pkg.sv
// rv_pkg: shared RISC-V decode definitions.
// Contents:
//   - base opcode constants for the RV32I major opcodes;
//   - FUNCT3_SR, the shift-right funct3 used to pick out SRAI/SRLI;
//   - fmt_flags_t, the one-hot instruction-format flag set that drives the
//     immediate-select logic in Stage2.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_SR  = 3'b101;

  // One-hot format flags; i_not_srai is the only bit allowed to ride along
  // with another one (it is always a subset of i).
  typedef struct packed {
    logic r;
    logic u;
    logic i;
    logic i_not_srai;
    logic sb;
    logic uj;
    logic s;
  } fmt_flags_t;

endpackage

// File: rtl/if_id_skid_decode_if.sv
// if_id_skid_decode_if: handshake bundle of the IF/ID boundary stage.
// Signals:
//   fetch side : in_valid, in_ready, in_instr, in_pc, flush
//   Stage2 side: out_valid, out_ready, out_instr, out_pc and the format
//                flags Rformat, Uformat, Iformat, IbutnotSRAIformat,
//                SBformat, UJformat, Sformat
//   illegal    : head opcode unrecognised, only when IFID_ILLEGAL_DETECT_EN
//                is defined.
// Modports:
//   slave  : the skid/decode stage itself
//   master : the environment (fetch + Stage2)
interface if_id_skid_decode_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            Rformat;
  logic            Uformat;
  logic            Iformat;
  logic            IbutnotSRAIformat;
  logic            SBformat;
  logic            UJformat;
  logic            Sformat;
`ifdef IFID_ILLEGAL_DETECT_EN
  logic            illegal;
`endif

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc,
    output Rformat, Uformat, Iformat, IbutnotSRAIformat,
    output SBformat, UJformat, Sformat
`ifdef IFID_ILLEGAL_DETECT_EN
    , output illegal
`endif
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc,
    input  Rformat, Uformat, Iformat, IbutnotSRAIformat,
    input  SBformat, UJformat, Sformat
`ifdef IFID_ILLEGAL_DETECT_EN
    , input illegal
`endif
  );

endinterface

// File: rtl/rv_format_decode.sv
// rv_format_decode: purely combinational RV32I instruction-format decoder.
// Ports:
//   instr_i   in  32  instruction word
//   flags_o   out 7   one-hot format flags (i_not_srai rides with i)
//   illegal_o out 1   opcode not one of the recognised major opcodes
module rv_format_decode
  import rv_pkg::*;
(
  input  logic [31:0] instr_i,
  output fmt_flags_t  flags_o,
  output logic        illegal_o
);

  logic [6:0] opcode_s;
  logic       is_srai_s;

  assign opcode_s  = instr_i[6:0];
  // SRAI is the only I-type whose imm field is not a plain sign-extended
  // 12-bit value (bit 30 selects arithmetic shift), so Stage2 needs it split.
  assign is_srai_s = (opcode_s == OPC_OPIMM) && (instr_i[14:12] == FUNCT3_SR)
                     && instr_i[30];

  // Map the major opcode onto its format class.
  always_comb begin
    flags_o   = fmt_flags_t'(7'b0);
    illegal_o = 1'b0;
    case (opcode_s)
      OPC_OP:                 flags_o.r = 1'b1;
      OPC_LUI, OPC_AUIPC:     flags_o.u = 1'b1;
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM: begin
        flags_o.i          = 1'b1;
        flags_o.i_not_srai = ~is_srai_s;
      end
      OPC_STORE:              flags_o.s  = 1'b1;
      OPC_BRANCH:             flags_o.sb = 1'b1;
      OPC_JAL:                flags_o.uj = 1'b1;
      default:                illegal_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_skid_decode.sv
// if_id_skid_decode: IF/ID boundary stage with a 2-entry skid buffer.
// Instructions are decoded once at enqueue; the head entry (instr, pc and
// registered format flags) is presented to Stage2.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  if_id_skid_decode_if.slave (fetch handshake, Stage2 handshake,
//        flush, head outputs and format flags)
// Configuration:
//   IFID_ILLEGAL_DETECT_EN defined -> per-entry illegal bit and illegal port.
module if_id_skid_decode
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  if_id_skid_decode_if.slave    bus
);

  logic [XLEN-1:0] instr_q [2];
  logic [XLEN-1:0] pc_q    [2];
  fmt_flags_t      flags_q [2];
  logic            head_q;
  logic [1:0]      count_q;
  logic [1:0]      count_d;
  logic            in_ready_q;

  logic            out_valid_s;
  logic            push_s;
  logic            pop_s;
  logic            tail_s;
  fmt_flags_t      dec_flags_s;
  fmt_flags_t      head_flags_s;
`ifdef IFID_ILLEGAL_DETECT_EN
  logic            illegal_q [2];
  logic            dec_illegal_s;
`else
  logic            dec_illegal_unused_s;
`endif

  rv_format_decode u_decode (
    .instr_i   (bus.in_instr[31:0]),
    .flags_o   (dec_flags_s),
`ifdef IFID_ILLEGAL_DETECT_EN
    .illegal_o (dec_illegal_s)
`else
    .illegal_o (dec_illegal_unused_s)
`endif
  );

  assign out_valid_s = (count_q != 2'd0);
  // in_ready comes from a register, so out_ready never reaches in_ready
  // combinationally; the second entry absorbs the beat that arrives while
  // the full indication is still in flight.
  assign push_s      = bus.in_valid & in_ready_q & ~bus.flush;
  assign pop_s       = out_valid_s & bus.out_ready & ~bus.flush;
  assign tail_s      = head_q ^ count_q[0];

  // Next occupancy; flush dominates both push and pop.
  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, occupancy and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d < 2'd2);
      if (bus.flush) begin
        head_q <= 1'b0;
      end else if (pop_s) begin
        head_q <= ~head_q;
      end else begin
        head_q <= head_q;
      end
    end
  end

  // Entry storage, written at the tail on push with freshly decoded flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        instr_q[k]   <= {XLEN{1'b0}};
        pc_q[k]      <= {XLEN{1'b0}};
        flags_q[k]   <= fmt_flags_t'(7'b0);
`ifdef IFID_ILLEGAL_DETECT_EN
        illegal_q[k] <= 1'b0;
`endif
      end
    end else if (push_s) begin
      instr_q[tail_s]   <= bus.in_instr;
      pc_q[tail_s]      <= bus.in_pc;
      flags_q[tail_s]   <= dec_flags_s;
`ifdef IFID_ILLEGAL_DETECT_EN
      illegal_q[tail_s] <= dec_illegal_s;
`endif
    end
  end

  // Head outputs are forced to zero while the buffer is empty.
  assign head_flags_s          = out_valid_s ? flags_q[head_q] : fmt_flags_t'(7'b0);
  assign bus.in_ready          = in_ready_q;
  assign bus.out_valid         = out_valid_s;
  assign bus.out_instr         = out_valid_s ? instr_q[head_q] : {XLEN{1'b0}};
  assign bus.out_pc            = out_valid_s ? pc_q[head_q]    : {XLEN{1'b0}};
  assign bus.Rformat           = head_flags_s.r;
  assign bus.Uformat           = head_flags_s.u;
  assign bus.Iformat           = head_flags_s.i;
  assign bus.IbutnotSRAIformat = head_flags_s.i_not_srai;
  assign bus.SBformat          = head_flags_s.sb;
  assign bus.UJformat          = head_flags_s.uj;
  assign bus.Sformat           = head_flags_s.s;
`ifdef IFID_ILLEGAL_DETECT_EN
  assign bus.illegal           = out_valid_s & illegal_q[head_q];
`endif

endmodule

// File: tb/tb_if_id_skid_decode.sv
// tb_if_id_skid_decode: scoreboard bench for if_id_skid_decode.
// The driver pushes the expected head record into exp_q whenever a beat is
// accepted; the monitor compares the DUT head against exp_q every cycle and
// retires entries on consume/flush.
module tb_if_id_skid_decode;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  flags;   // {R, U, I, IbutnotSRAI, SB, UJ, S}
    logic        ill;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  if_id_skid_decode_if #(.XLEN(32)) bus ();

  if_id_skid_decode #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [6:0] op;
    logic srai;
    op      = ins[6:0];
    e.instr = ins;
    e.pc    = pc;
    e.flags = 7'b0000000;
    e.ill   = 1'b0;
    srai    = (op == 7'h13) && (ins[14:12] == 3'd5) && ins[30];
    if (op == 7'h33)                                   e.flags = 7'b1000000;
    else if (op inside {7'h37, 7'h17})                 e.flags = 7'b0100000;
    else if (op inside {7'h03, 7'h13, 7'h67, 7'h0F, 7'h73})
      e.flags = srai ? 7'b0010000 : 7'b0011000;
    else if (op == 7'h63)                              e.flags = 7'b0000100;
    else if (op == 7'h6F)                              e.flags = 7'b0000010;
    else if (op == 7'h23)                              e.flags = 7'b0000001;
    else                                               e.ill   = 1'b1;
    return e;
  endfunction

  function automatic logic [6:0] dut_flags();
    return {bus.Rformat, bus.Uformat, bus.Iformat, bus.IbutnotSRAIformat,
            bus.SBformat, bus.UJformat, bus.Sformat};
  endfunction

  // One cycle of stimulus: inputs change 2 time units after negedge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, output logic acc);
    @(negedge clk);
    #2;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    acc = v && bus.in_ready && !fl;
    if (acc) exp_q.push_back(model(ins, pc));
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) cycle(1'b1, ins, pc, ordy, 1'b0, acc);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_accepted expected=accepted pc=%h", pc);
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 32'h0, ordy, 1'b0, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_in_ready"},  {31'b0, bus.in_ready},  32'd1);
    chk({tag, "_out_instr"}, bus.out_instr, 32'd0);
    chk({tag, "_out_pc"},    bus.out_pc,    32'd0);
    chk({tag, "_flags"},     {25'b0, dut_flags()}, 32'd0);
`ifdef IFID_ILLEGAL_DETECT_EN
    chk({tag, "_illegal"},   {31'b0, bus.illegal}, 32'd0);
`endif
  endtask

  // Monitor: compare head at negedge, retire at negedge+4 (inputs settled).
  initial begin
    exp_t h;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_q.size() != 0});
        chk("in_ready",  {31'b0, bus.in_ready},  {31'b0, exp_q.size() < 2});
        if (exp_q.size() != 0) begin
          h = exp_q[0];
          chk("out_instr", bus.out_instr, h.instr);
          chk("out_pc",    bus.out_pc,    h.pc);
          chk("flags",     {25'b0, dut_flags()}, {25'b0, h.flags});
`ifdef IFID_ILLEGAL_DETECT_EN
          chk("illegal",   {31'b0, bus.illegal}, {31'b0, h.ill});
`endif
        end else begin
          chk("idle_instr", bus.out_instr, 32'd0);
          chk("idle_flags", {25'b0, dut_flags()}, 32'd0);
        end
      end
      #4;
      if (!rst) begin
        if (bus.flush) begin
          exp_q.delete();
        end else if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pop actual=out_valid expected=empty");
          end else begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Driver.
  initial begin
    logic acc;
    logic [31:0] r;
    logic [31:0] ins;
    logic [6:0]  ops [12];
    logic [31:0] pc;
    ops = '{7'h33, 7'h37, 7'h17, 7'h03, 7'h13, 7'h67,
            7'h0F, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h7F};
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    bus.in_pc = 32'h0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    #1 rst = 1'b0;

    // Directed decode patterns, consumer always ready.
    send(32'h00500093, 32'h0000_1000, 1'b1);   // ADDI
    send(32'h40315093, 32'h0000_1004, 1'b1);   // SRAI
    send(32'h123450B7, 32'h0000_1008, 1'b1);   // LUI
    send(32'h0000006F, 32'h0000_100C, 1'b1);   // JAL
    send(32'h00112023, 32'h0000_1010, 1'b1);   // SW
    send(32'h00208463, 32'h0000_1014, 1'b1);   // BEQ
    send(32'h002081B3, 32'h0000_1018, 1'b1);   // ADD
    send(32'h0000007F, 32'h0000_101C, 1'b1);   // unrecognised opcode
    idle(3, 1'b1);

    // Stall: two accepted, third held by fetch until out_ready returns.
    send(32'h00100113, 32'h0000_2000, 1'b0);
    send(32'h00200193, 32'h0000_2004, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'h00300213, 32'h0000_2008, 1'b0, 1'b0, acc);
      chk("stall_third_held", {31'b0, acc}, 32'd0);
    end
    send(32'h00300213, 32'h0000_2008, 1'b1);
    idle(4, 1'b1);

    // Flush with two buffered and a valid beat in the flush cycle.
    send(32'h00400293, 32'h0000_3000, 1'b0);
    send(32'h00500313, 32'h0000_3004, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 32'h00600393, 32'h0000_3008, 1'b0, 1'b1, acc);
    chk("flush_beat_dropped", {31'b0, acc}, 32'd0);
    idle(2, 1'b1);

    // Randomized traffic.
    pc = 32'h0001_0000;
    for (int k = 0; k < 400; k++) begin
      r   = $urandom();
      ins = {r[31:7], ops[$urandom_range(0, 11)]};
      cycle($urandom_range(0, 3) != 0, ins, pc, $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0, acc);
      if (acc) pc = pc + 32'd4;
    end
    idle(3, 1'b1);

    // Asynchronous reset with two entries buffered.
    send(32'h00700413, 32'h0000_4000, 1'b0);
    send(32'h00800493, 32'h0000_4004, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    send(32'h00900513, 32'h0000_5000, 1'b1);
    idle(3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
